// File: rtl/line_buf_pkg.sv
// line_buf_pkg: width-ratio and sizing helpers shared by the line buffer files
package line_buf_pkg;
  function automatic int ratio(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction
  function automatic int sub_w(input int r);
    return r > 1 ? $clog2(r) : 1;
  endfunction
  function automatic int ptr_w(input int words);
    return words > 1 ? $clog2(words) : 1;
  endfunction
  function automatic bit is_pow2(input int v);
    return v > 0 && (v & (v - 1)) == 0;
  endfunction
endpackage

// File: rtl/line_buffer_wc_sdp_ram.sv
// sdp_ram: single-clock simple dual-port RAM with registered read, array not reset
module sdp_ram
  import line_buf_pkg::*;
#(
  parameter int W = 16,
  parameter int D = 1024
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ptr_w(D)-1:0]   waddr,
  input  logic [W-1:0]          wdata,
  input  logic                  re,
  input  logic [ptr_w(D)-1:0]   raddr,
  output logic [W-1:0]          rdata
);
  logic [W-1:0] mem [D];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/line_buffer_wc.sv
// line_buffer_wc: line FIFO with IN_W->OUT_W down-conversion, level, line_rdy and stretched error
module line_buffer_wc
  import line_buf_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 8,
  parameter int DEPTH     = 2048,
  parameter int LINE_LEN  = 1280,
  parameter int ERR_HOLD  = 37_500_000,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wen,
  input  logic [IN_W-1:0]        wdata,
  output logic                   wfull,
  input  logic                   ren,
  output logic [OUT_W-1:0]       rdata,
  output logic                   rvalid,
  output logic                   rempty,
  output logic                   line_rdy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   error
);
  localparam int R     = ratio(IN_W, OUT_W);
  localparam int WORDS = DEPTH / R;
  localparam int PTR_W = ptr_w(WORDS);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int SUB_W = sub_w(R);
  localparam int CNT_W = $clog2(ERR_HOLD) + 1;

  if (IN_W % OUT_W != 0) begin : g_chk_w
    $error("IN_W must be a multiple of OUT_W");
  end
  if (!is_pow2(R)) begin : g_chk_r
    $error("IN_W/OUT_W must be a power of 2");
  end
  if (!is_pow2(DEPTH) || DEPTH % R != 0) begin : g_chk_d
    $error("DEPTH must be a power of 2 and a multiple of IN_W/OUT_W");
  end
  if (LINE_LEN < 1 || LINE_LEN > DEPTH || ERR_HOLD < 1) begin : g_chk_l
    $error("LINE_LEN must be 1..DEPTH and ERR_HOLD >= 1");
  end

  logic [PTR_W-1:0] wptr, rptr;
  logic [SUB_W-1:0] sub, sub_q, idx;
  logic [LVL_W-1:0] lvl_nxt;
  logic [CNT_W-1:0] cnt;
  logic [IN_W-1:0]  ram_q;
  logic             wacc, racc, fault, last, has_data;

  assign wacc  = wen && !wfull;
  assign racc  = ren && !rempty;
  assign fault = (wen && wfull) || (ren && rempty);
  assign last  = sub == SUB_W'(R - 1);
  assign lvl_nxt = level + (wacc ? LVL_W'(R) : LVL_W'(0)) - (racc ? LVL_W'(1) : LVL_W'(0));

  sdp_ram #(.W(IN_W), .D(WORDS)) u_ram (
    .clk   (clk),
    .we    (wacc),
    .waddr (wptr),
    .wdata (wdata),
    .re    (racc),
    .raddr (rptr),
    .rdata (ram_q)
  );

  // sub_q remembers which slice the registered RAM word is to yield
  assign idx = LSB_FIRST ? sub_q : SUB_W'(R - 1) - sub_q;
  always_comb rdata = has_data ? ram_q[int'(idx) * OUT_W +: OUT_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      sub      <= '0;
      sub_q    <= '0;
      has_data <= 1'b0;
      level    <= '0;
      wfull    <= 1'b0;
      rempty   <= 1'b1;
      line_rdy <= 1'b0;
      rvalid   <= 1'b0;
      cnt      <= '0;
      error    <= 1'b0;
    end else begin
      if (wacc) wptr <= PTR_W'((int'(wptr) + 1) % WORDS);
      if (racc) begin
        sub      <= last ? '0 : sub + 1'b1;
        sub_q    <= sub;
        has_data <= 1'b1;
        if (last) rptr <= PTR_W'((int'(rptr) + 1) % WORDS);
      end
      rvalid   <= racc;
      level    <= lvl_nxt;
      wfull    <= lvl_nxt > LVL_W'(DEPTH - R);
      rempty   <= lvl_nxt == '0;
      line_rdy <= lvl_nxt >= LVL_W'(LINE_LEN);
      cnt      <= fault ? CNT_W'(ERR_HOLD - 1) : (cnt != '0 ? cnt - 1'b1 : cnt);
      error    <= fault || cnt != '0;
    end
  end
endmodule

// File: tb/tb_line_buffer_wc.sv
// tb_line_buffer_wc: directed checks of line_buffer_wc in both packing orders
module tb_line_buffer_wc;
  logic        clk = 1'b0;
  logic        rst, wen, ren;
  logic [15:0] wdata;
  logic        a_wfull, a_rvalid, a_rempty, a_line_rdy, a_error;
  logic [7:0]  a_rdata;
  logic [11:0] a_level;
  logic        b_wfull, b_rvalid, b_rempty, b_line_rdy, b_error;
  logic [7:0]  b_rdata;
  logic [11:0] b_level;
  logic [7:0]  q[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  line_buffer_wc #(.ERR_HOLD(10), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .wfull(a_wfull), .ren(ren),
    .rdata(a_rdata), .rvalid(a_rvalid), .rempty(a_rempty), .line_rdy(a_line_rdy),
    .level(a_level), .error(a_error)
  );

  line_buffer_wc #(.ERR_HOLD(10), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .wfull(b_wfull), .ren(ren),
    .rdata(b_rdata), .rvalid(b_rvalid), .rempty(b_rempty), .line_rdy(b_line_rdy),
    .level(b_level), .error(b_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] d);
    wen = 1'b1;
    wdata = d;
    tick();
    wen = 1'b0;
    q.push_back(d[7:0]);
    q.push_back(d[15:8]);
  endtask

  task automatic test_reset();
    rst = 1'b1; wen = 1'b0; ren = 1'b0; wdata = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (a_level !== 12'd0) begin errors++; $display("FAIL reset_level got %0d want 0", a_level); end
    checks++; if (a_rempty !== 1'b1 || a_wfull !== 1'b0) begin errors++; $display("FAIL reset_flags rempty=%b wfull=%b want 1 0", a_rempty, a_wfull); end
    checks++; if (a_rvalid !== 1'b0 || a_rdata !== 8'h00) begin errors++; $display("FAIL reset_rd rvalid=%b rdata=%h want 0 00", a_rvalid, a_rdata); end
    checks++; if (a_line_rdy !== 1'b0 || a_error !== 1'b0) begin errors++; $display("FAIL reset_misc line_rdy=%b error=%b want 0 0", a_line_rdy, a_error); end
  endtask

  task automatic test_packing();
    logic [7:0] ea [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] eb [4] = '{8'h22, 8'h11, 8'h44, 8'h33};
    wr(16'h2211); wr(16'h4433);
    checks++; if (a_level !== 12'd4) begin errors++; $display("FAIL pack_level got %0d want 4", a_level); end
    ren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (a_rvalid !== 1'b1 || a_rdata !== ea[i]) begin errors++; $display("FAIL pack_lsb[%0d] rvalid=%b rdata=%h want 1 %h", i, a_rvalid, a_rdata, ea[i]); end
      checks++; if (b_rvalid !== 1'b1 || b_rdata !== eb[i]) begin errors++; $display("FAIL pack_msb[%0d] rvalid=%b rdata=%h want 1 %h", i, b_rvalid, b_rdata, eb[i]); end
    end
    ren = 1'b0;
    checks++; if (a_rempty !== 1'b1) begin errors++; $display("FAIL pack_empty got %b want 1", a_rempty); end
    tick();
    checks++; if (a_rvalid !== 1'b0 || a_rdata !== 8'h44) begin errors++; $display("FAIL pack_hold rvalid=%b rdata=%h want 0 44", a_rvalid, a_rdata); end
    q.delete();
  endtask

  task automatic test_fill();
    logic [7:0] exp;
    for (int i = 0; i < 1024; i++) begin
      wr(16'(i * 3) ^ 16'h5A5A);
      if (i == 638) begin
        checks++; if (a_line_rdy !== 1'b0 || a_level !== 12'd1278) begin errors++; $display("FAIL fill_639 line_rdy=%b level=%0d want 0 1278", a_line_rdy, a_level); end
      end
      if (i == 639) begin
        checks++; if (a_line_rdy !== 1'b1 || a_level !== 12'd1280) begin errors++; $display("FAIL fill_640 line_rdy=%b level=%0d want 1 1280", a_line_rdy, a_level); end
      end
      if (i == 1022) begin
        checks++; if (a_wfull !== 1'b0) begin errors++; $display("FAIL fill_1023_wfull got %b want 0", a_wfull); end
      end
    end
    checks++; if (a_wfull !== 1'b1 || a_level !== 12'd2048) begin errors++; $display("FAIL fill_full wfull=%b level=%0d want 1 2048", a_wfull, a_level); end
    checks++; if (a_error !== 1'b0) begin errors++; $display("FAIL fill_noerr got %b want 0", a_error); end
    wen = 1'b1; wdata = 16'hDEAD;
    tick();
    wen = 1'b0;
    checks++; if (a_level !== 12'd2048 || a_error !== 1'b1) begin errors++; $display("FAIL overflow level=%0d error=%b want 2048 1", a_level, a_error); end
    ren = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      tick();
      exp = q.pop_front();
      checks++; if (a_rvalid !== 1'b1 || a_rdata !== exp) begin errors++; $display("FAIL fill_drain[%0d] rvalid=%b rdata=%h want 1 %h", i, a_rvalid, a_rdata, exp); end
    end
    ren = 1'b0;
    checks++; if (a_rempty !== 1'b1 || a_level !== 12'd0) begin errors++; $display("FAIL fill_empty rempty=%b level=%0d want 1 0", a_rempty, a_level); end
  endtask

  task automatic test_underflow();
    checks++; if (a_error !== 1'b0) begin errors++; $display("FAIL udf_pre error=%b want 0", a_error); end
    ren = 1'b1;
    tick();
    ren = 1'b0;
    checks++; if (a_rvalid !== 1'b0 || a_level !== 12'd0 || a_error !== 1'b1) begin errors++; $display("FAIL udf_first rvalid=%b level=%0d error=%b want 0 0 1", a_rvalid, a_level, a_error); end
    for (int k = 2; k <= 11; k++) begin
      tick();
      checks++; if (a_error !== (k <= 10)) begin errors++; $display("FAIL udf_stretch[%0d] error=%b want %b", k, a_error, k <= 10); end
    end
    ren = 1'b1;
    tick();
    ren = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      checks++; if (a_error !== 1'b1) begin errors++; $display("FAIL udf_a[%0d] error=%b want 1", k, a_error); end
    end
    ren = 1'b1;
    tick();
    ren = 1'b0;
    for (int k = 2; k <= 11; k++) begin
      tick();
      checks++; if (a_error !== (k <= 10)) begin errors++; $display("FAIL udf_retrig[%0d] error=%b want %b", k, a_error, k <= 10); end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    wr(16'hBBAA);
    ren = 1'b1;
    tick();
    ren = 1'b0;
    exp = q.pop_front();
    checks++; if (a_rdata !== exp || a_level !== 12'd1) begin errors++; $display("FAIL sim_pre rdata=%h level=%0d want %h 1", a_rdata, a_level, exp); end
    wen = 1'b1; ren = 1'b1; wdata = 16'hDDCC;
    tick();
    wen = 1'b0; ren = 1'b0;
    q.push_back(8'hCC); q.push_back(8'hDD);
    exp = q.pop_front();
    checks++; if (a_level !== 12'd2 || a_rvalid !== 1'b1 || a_rdata !== exp) begin errors++; $display("FAIL sim_both level=%0d rvalid=%b rdata=%h want 2 1 %h", a_level, a_rvalid, a_rdata, exp); end
    ren = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp = q.pop_front();
      checks++; if (a_rvalid !== 1'b1 || a_rdata !== exp) begin errors++; $display("FAIL sim_tail[%0d] rdata=%h want %h", i, a_rdata, exp); end
    end
    ren = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 1024; i++) wr(16'(p * 1024 + i) ^ 16'hA5C3);
      ren = 1'b1;
      for (int i = 0; i < 2048; i++) begin
        tick();
        exp = q.pop_front();
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== exp) begin errors++; $display("FAIL wrap_p%0d[%0d] rvalid=%b rdata=%h want 1 %h", p, i, a_rvalid, a_rdata, exp); end
      end
      ren = 1'b0;
    end
    checks++; if (a_rempty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b want 1", a_rempty); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 350; i++) wr(16'(i));
    checks++; if (a_level !== 12'd700) begin errors++; $display("FAIL rmid_level got %0d want 700", a_level); end
    ren = 1'b1;
    tick();
    checks++; if (a_rvalid !== 1'b1) begin errors++; $display("FAIL rmid_inflight rvalid=%b want 1", a_rvalid); end
    rst = 1'b1;
    tick();
    rst = 1'b0; ren = 1'b0;
    q.delete();
    checks++; if (a_level !== 12'd0 || a_rempty !== 1'b1 || a_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_state level=%0d rempty=%b rvalid=%b want 0 1 0", a_level, a_rempty, a_rvalid); end
    checks++; if (a_error !== 1'b0 || a_line_rdy !== 1'b0 || a_rdata !== 8'h00) begin errors++; $display("FAIL rmid_misc error=%b line_rdy=%b rdata=%h want 0 0 00", a_error, a_line_rdy, a_rdata); end
    wr(16'h1234); wr(16'h5678);
    ren = 1'b1;
    tick();
    ren = 1'b0;
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 8'h34) begin errors++; $display("FAIL rmid_first rvalid=%b rdata=%h want 1 34", a_rvalid, a_rdata); end
    checks++; if (b_rdata !== 8'h12) begin errors++; $display("FAIL rmid_first_msb rdata=%h want 12", b_rdata); end
  endtask

  initial begin
    test_reset();
    test_packing();
    test_fill();
    test_underflow();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
